// File: rtl/arc4_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : arc4_pkg
// Purpose : Shared ARC4 definitions for the init, KSA and PRGA stages:
//           byte-width constants and the PRGA state encoding.
// Rev     : 1.0  initial release
// ============================================================================
package arc4_pkg;

  localparam int ARC4_W = 8;    // data and address width
  localparam int ARC4_N = 256;  // entries in the S permutation

  // One state per memory cycle of the PRGA loop.
  typedef enum logic [3:0] {
    PRGA_IDLE    = 4'd0,
    PRGA_RD_LEN  = 4'd1,
    PRGA_GOT_LEN = 4'd2,
    PRGA_WR_LEN  = 4'd3,
    PRGA_RD_I    = 4'd4,
    PRGA_GOT_I   = 4'd5,
    PRGA_RD_J    = 4'd6,
    PRGA_GOT_J   = 4'd7,
    PRGA_WR_I    = 4'd8,
    PRGA_WR_J    = 4'd9,
    PRGA_RD_PAD  = 4'd10,
    PRGA_WR_PT   = 4'd11
  } prga_state_t;

endpackage : arc4_pkg
`default_nettype wire

// File: rtl/prga.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : prga
// Purpose : ARC4 pseudo-random generation stage. On an accepted en it reads a
//           length-prefixed ciphertext from ct_mem, produces one keystream
//           byte per message byte (swapping S entries in s_mem as it goes),
//           and writes the length-prefixed plaintext to pt_mem.
// Ports   : clk, rst        clock and asynchronous active-high reset
//           en / rdy        start request / idle handshake
//           s_*             S memory (read/write, 1-cycle read latency)
//           ct_*            ciphertext memory (read-only, 1-cycle latency)
//           pt_*            plaintext memory (write-only)
// Rev     : 1.0  initial release
// ============================================================================
module prga
  import arc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ARC4_W-1:0] s_addr,
  input  logic [ARC4_W-1:0] s_rddata,
  output logic [ARC4_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ARC4_W-1:0] ct_addr,
  input  logic [ARC4_W-1:0] ct_rddata,
  output logic [ARC4_W-1:0] pt_addr,
  output logic [ARC4_W-1:0] pt_wrdata,
  output logic              pt_wren
);

  prga_state_t       state_q, state_d;
  logic [ARC4_W-1:0] i_q,   i_d;
  logic [ARC4_W-1:0] j_q,   j_d;
  logic [ARC4_W-1:0] k_q,   k_d;
  logic [ARC4_W-1:0] len_q, len_d;
  logic [ARC4_W-1:0] si_q,  si_d;
  logic [ARC4_W-1:0] sj_q,  sj_d;
  logic [ARC4_W-1:0] ctb_q, ctb_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PRGA_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ctb_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ctb_q   <= ctb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ctb_d     = ctb_q;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;

    unique case (state_q)
      PRGA_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          j_d     = '0;
          state_d = PRGA_RD_LEN;
        end
      end
      PRGA_RD_LEN: begin
        ct_addr = '0;
        state_d = PRGA_GOT_LEN;
      end
      PRGA_GOT_LEN: begin
        len_d   = ct_rddata;
        state_d = PRGA_WR_LEN;
      end
      PRGA_WR_LEN: begin
        pt_addr   = '0;
        pt_wrdata = len_q;
        pt_wren   = 1'b1;
        if (len_q == '0) begin
          state_d = PRGA_IDLE;
        end else begin
          // i is pre-incremented in ARC4, so the first byte uses i = 1.
          i_d     = 8'd1;
          k_d     = 8'd1;
          state_d = PRGA_RD_I;
        end
      end
      PRGA_RD_I: begin
        // S[i] and the ciphertext byte are fetched in the same cycle.
        s_addr  = i_q;
        ct_addr = k_q;
        state_d = PRGA_GOT_I;
      end
      PRGA_GOT_I: begin
        si_d    = s_rddata;
        ctb_d   = ct_rddata;
        j_d     = j_q + s_rddata;
        state_d = PRGA_RD_J;
      end
      PRGA_RD_J: begin
        s_addr  = j_q;
        state_d = PRGA_GOT_J;
      end
      PRGA_GOT_J: begin
        sj_d    = s_rddata;
        state_d = PRGA_WR_I;
      end
      PRGA_WR_I: begin
        // When i == j both writes store the same byte; S is unchanged.
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = PRGA_WR_J;
      end
      PRGA_WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = PRGA_RD_PAD;
      end
      PRGA_RD_PAD: begin
        // Pad index uses the pre-swap values, which equal post-swap S[i]+S[j].
        s_addr  = si_q + sj_q;
        state_d = PRGA_WR_PT;
      end
      PRGA_WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ctb_q;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = PRGA_IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = k_q + 8'd1;
          state_d = PRGA_RD_I;
        end
      end
      default: begin
        state_d = PRGA_IDLE;
      end
    endcase
  end

endmodule : prga
`default_nettype wire

// File: doc/prga.md
# prga

ARC4 pseudo-random generation stage: the consumer of the permuted S array left in `s_mem` by the init + key-scheduling stages. On an `en` pulse it reads a length-prefixed ciphertext from `ct_mem`, generates one keystream byte per message byte, and writes the length-prefixed plaintext to `pt_mem`. While it runs it also applies the PRGA swaps to `s_mem`. It sits between the KSA stage and the top-level result/HEX logic, and uses the same `en`/`rdy` handshake as the other ARC4 stages.

## Interface
Parameters: none; all widths are fixed by ARC4 (8-bit data, 8-bit addresses).
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: start request; sampled only while `rdy`=1.
- `rdy` out 1: idle and able to accept `en`.
- `s_addr` out 8: S memory address.
- `s_rddata` in 8: S memory read data.
- `s_wrdata` out 8: S memory write data.
- `s_wren` out 1: S memory write enable.
- `ct_addr` out 8: ciphertext memory address (read-only memory).
- `ct_rddata` in 8: ciphertext read data.
- `pt_addr` out 8: plaintext memory address.
- `pt_wrdata` out 8: plaintext write data.
- `pt_wren` out 1: plaintext write enable.

## Operation
- Memories are synchronous single-port. An address driven in cycle n returns its data in cycle n+1. Writes commit at the end of the cycle in which `wren`=1.
- Message format: `ct[0]` = length L (0..255); `ct[1..L]` = ciphertext bytes. The block writes `pt[0]`=L and `pt[k]` = `ct[k]` XOR pad_k.
- Registers: `i`, `j`, `k` (8-bit), `len`, `si`, `sj`, `ctb` (8-bit). All arithmetic is mod 256 with natural 8-bit wrap; `j` wraps freely.
- FSM states, one cycle each:
  - IDLE: `rdy`=1. `en`=1 → clear `j`; go to RD_LEN.
  - RD_LEN: `ct_addr`=0.
  - GOT_LEN: `len`←`ct_rddata`.
  - WR_LEN: `pt_addr`=0, `pt_wrdata`=`len`, `pt_wren`=1. If `len`=0 → IDLE; else `i`←1, `k`←1, go to RD_I.
  - RD_I: `s_addr`=`i`, `ct_addr`=`k`.
  - GOT_I: `si`←`s_rddata`, `ctb`←`ct_rddata`, `j`←`j`+`s_rddata`.
  - RD_J: `s_addr`=`j`.
  - GOT_J: `sj`←`s_rddata`.
  - WR_I: `s_addr`=`i`, `s_wrdata`=`sj`, `s_wren`=1.
  - WR_J: `s_addr`=`j`, `s_wrdata`=`si`, `s_wren`=1.
  - RD_PAD: `s_addr`=`si`+`sj`.
  - WR_PT: `pt_addr`=`k`, `pt_wrdata`=`s_rddata` XOR `ctb`, `pt_wren`=1. If `k`=`len` → IDLE; else `i`++, `k`++, go to RD_I.
- Case `i`=`j`: both swap writes store the same value, so S is unchanged. This is correct and needs no special handling.
- `en` outside IDLE is ignored; no queuing.
- `i` starts at 0 and is pre-incremented, so the first byte uses `i`=1 (standard ARC4).

## Timing
- Reset values: state=IDLE, `rdy`=1, all address/data outputs 0, all `wren`=0, all registers 0.
- Reset mid-operation: returns to IDLE on the next sample and abandons the run. Partially written `pt`/`s` contents are left as-is.
- `rdy` falls in the cycle after `en` is accepted. It rises again exactly 3+8·L cycles after the accepting edge (L=0: 3 cycles; L=255: 2043 cycles).
- At most one `wren` is asserted per cycle. Write enables are never asserted in IDLE.
- Combinational outputs are decoded from state and registers only. There is no combinational path from `en` to any memory output.

## Structure
- Package `arc4_pkg` holds:
  - the `prga_state_t` enum;
  - byte-width constants (`ARC4_W`=8, `ARC4_N`=256) shared with the init/KSA stages.
- No sub-module. The block is one FSM plus datapath registers.
- `task3` top instantiates `prga` alongside the existing `s_mem`, `ct_mem` and `pt_mem` IP and chains `rdy`→`en` from the KSA stage.

## Test plan
- Identity S (S[x]=x), L=3, ct=03,A0,B0,C0 → pads 02,05,07; pt=03,A2,B5,C7. Final S[2]=03, S[3]=05, S[5]=02, all other entries unchanged.
- L=0 (ct[0]=00) → pt[0]=00, no `s_wren`, `rdy` back high 3 cycles after accept.
- L=255 with a random S from a reference model → pt matches the model byte-for-byte, `j` wraps correctly, `rdy` returns after 2043 cycles.
- Pulse `en` again during a run at byte 2 → ignored; output identical to the single-request run.
- Assert `rst` in the WR_I state of byte 2 → `rdy`=1 and all `wren`=0 immediately; a following `en` completes a clean full run.
- S chained from the KSA stage with key 00033C, using the stored ciphertext → pt bytes are all printable ASCII.
